// File: rtl/load_handler.sv
// load_handler: burst read engine for the synchronous data memory.
// Accepts a start address and a word count, issues one read per cycle,
// follows the memory's fixed read latency with a token shift register, and
// returns each word with a one-cycle valid strobe. The ready flag stays high
// until the requester drops enable.
module load_handler #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned DATA_MEMORY_SIZE = 64,
    parameter int unsigned READ_LATENCY     = 1,
    parameter int unsigned MAX_BURST        = 4,
    localparam int unsigned AW = $clog2(DATA_MEMORY_SIZE),
    localparam int unsigned LW = $clog2(MAX_BURST) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [AW-1:0]         src_addr,
    input  logic [LW-1:0]         burst_len,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [AW-1:0]         addr_out,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_q,   state_d;
    logic [LW-1:0]           len_q,     len_d;
    logic [LW-1:0]           iss_cnt_q, iss_cnt_d;
    logic [LW-1:0]           ret_cnt_q, ret_cnt_d;
    logic [READ_LATENCY-1:0] tok_q,     tok_d;
    logic                    rd_en_q,   rd_en_d;
    logic [AW-1:0]           addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic                    valid_q,   valid_d;
    logic                    ready_q,   ready_d;

    logic [LW-1:0]           eff_len;
    logic [AW-1:0]           addr_inc;
    logic [READ_LATENCY-1:0] tok_shift;
    logic                    tok_last;

    // Clamp the requested length: zero means one word, oversize means MAX_BURST.
    always_comb begin
        if (burst_len == '0) begin
            eff_len = LW'(1);
        end else if (burst_len > LW'(MAX_BURST)) begin
            eff_len = LW'(MAX_BURST);
        end else begin
            eff_len = burst_len;
        end
    end

    // Next read address, wrapping at the top of memory (also for non-power-of-two sizes).
    always_comb begin
        if (addr_q == AW'(DATA_MEMORY_SIZE - 1)) begin
            addr_inc = '0;
        end else begin
            addr_inc = addr_q + 1'b1;
        end
    end

    // Token pipe advance: a token enters with every registered read strobe.
    if (READ_LATENCY == 1) begin : g_tok_single
        always_comb tok_shift = rd_en_q;
    end else begin : g_tok_multi
        always_comb tok_shift = {tok_q[READ_LATENCY-2:0], rd_en_q};
    end

    // A token at the last stage means mem_data_in holds the matching word this cycle.
    always_comb tok_last = tok_q[READ_LATENCY-1];

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        iss_cnt_d = iss_cnt_q;
        ret_cnt_d = ret_cnt_q;
        tok_d     = '0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    // First read is launched on the accepting edge so rd_en is
                    // already high in the cycle after the request is sampled.
                    state_d   = ISSUE;
                    len_d     = eff_len;
                    addr_d    = src_addr;
                    rd_en_d   = 1'b1;
                    iss_cnt_d = LW'(1);
                    ret_cnt_d = '0;
                end
            end

            ISSUE: begin
                if (!enable) begin
                    state_d   = IDLE;
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                end else begin
                    // Short latencies return data while reads are still issuing.
                    tok_d = tok_shift;
                    if (tok_last) begin
                        data_d    = mem_data_in;
                        valid_d   = 1'b1;
                        ret_cnt_d = ret_cnt_q + 1'b1;
                    end
                    if (iss_cnt_q == len_q) begin
                        state_d = DRAIN;
                    end else begin
                        rd_en_d   = 1'b1;
                        addr_d    = addr_inc;
                        iss_cnt_d = iss_cnt_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (!enable) begin
                    state_d   = IDLE;
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                end else if (ret_cnt_q == len_q) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    tok_d = tok_shift;
                    if (tok_last) begin
                        data_d    = mem_data_in;
                        valid_d   = 1'b1;
                        ret_cnt_d = ret_cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                if (!enable) begin
                    state_d   = IDLE;
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                end else begin
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            tok_q     <= '0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            tok_q     <= tok_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign addr_out   = addr_q;
    assign rd_en      = rd_en_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign ready      = ready_q;

endmodule
